// File: rtl/py_sched.sv
// Payload-phase sequencer: latches per-slot packet configuration, issues the
// payload start pulse after the packet header, gates the 1 us data strobe and
// reports completion or timeout of the payload phase.
module py_sched (
  input  logic        clk_6M,
  input  logic        rstz,
  input  logic        p_1us,
  input  logic        tx_req,
  input  logic        rx_req,
  input  logic        abort,
  input  logic        mpr,
  input  logic        ir,
  input  logic [3:0]  regi_packet_type,
  input  logic [9:0]  regi_payloadlen,
  input  logic        header_endp,
  input  logic        py_period,
  input  logic        dec_py_period,
  output logic        py_st_p,
  output logic        py_datvalid_p,
  output logic [3:0]  pk_type,
  output logic [12:0] pylenbit,
  output logic        crcencode,
  output logic        fec31encode,
  output logic        fec32encode,
  output logic        pk_encode,
  output logic        existpyheader,
  output logic        BRss,
  output logic        busy,
  output logic        done_p,
  output logic        err_timeout,
  output logic        len_clamped
);

  typedef enum logic [2:0] {StIdle, StWaitHdr, StStart, StActive, StDone} state_e;

  localparam logic [11:0] TimeoutUs = 12'd3000;

  state_e      state_q, state_d;
  logic [11:0] us_cnt_q, us_cnt_d;
  logic [3:0]  pk_type_q, pk_type_d;
  logic [12:0] pylen_q, pylen_d;
  logic        crc_q, crc_d;
  logic        fec31_q, fec31_d;
  logic        fec32_q, fec32_d;
  logic        pk_encode_q, pk_encode_d;
  logic        hdr_q, hdr_d;
  logic        brss_q, brss_d;
  logic        nopay_q, nopay_d;
  logic        err_q, err_d;
  logic        clamp_q, clamp_d;

  // Decoded view of the currently requested packet; only latched on a request.
  logic [3:0]  eff_type;
  logic [8:0]  max_bytes;
  logic [4:0]  hdr_bits;
  logic [7:0]  fixed_bits;
  logic        dec_crc, dec_fec31, dec_fec32, dec_fixed, dec_nopay, dec_clamp;
  logic [9:0]  len_eff;
  logic [12:0] dec_pylen;

  // Packet-type decode and payload bit-length computation.
  always_comb begin
    eff_type   = (mpr | ir) ? 4'h2 : regi_packet_type;
    max_bytes  = 9'd0;
    hdr_bits   = 5'd0;
    fixed_bits = 8'd0;
    dec_crc    = 1'b0;
    dec_fec31  = 1'b0;
    dec_fec32  = 1'b0;
    dec_fixed  = 1'b0;
    dec_nopay  = 1'b0;
    case (eff_type)
      4'h2: begin dec_fixed = 1'b1; fixed_bits = 8'd144; dec_crc = 1'b1; dec_fec32 = 1'b1; end
      4'h3: begin max_bytes = 9'd17;  hdr_bits = 5'd8;  dec_crc = 1'b1; dec_fec32 = 1'b1; end
      4'h4: begin max_bytes = 9'd27;  hdr_bits = 5'd8;  dec_crc = 1'b1; end
      4'h5: begin dec_fixed = 1'b1; fixed_bits = 8'd80;  dec_fec31 = 1'b1; end
      4'h6: begin dec_fixed = 1'b1; fixed_bits = 8'd160; dec_fec32 = 1'b1; end
      4'h7: begin dec_fixed = 1'b1; fixed_bits = 8'd240; end
      4'h9: begin max_bytes = 9'd29;  hdr_bits = 5'd8;  end
      4'hA: begin max_bytes = 9'd121; hdr_bits = 5'd16; dec_crc = 1'b1; dec_fec32 = 1'b1; end
      4'hB: begin max_bytes = 9'd183; hdr_bits = 5'd16; dec_crc = 1'b1; end
      4'hE: begin max_bytes = 9'd224; hdr_bits = 5'd16; dec_crc = 1'b1; dec_fec32 = 1'b1; end
      4'hF: begin max_bytes = 9'd339; hdr_bits = 5'd16; dec_crc = 1'b1; end
      // NULL, POLL and the undefined codes carry no payload.
      default: dec_nopay = 1'b1;
    endcase

    dec_clamp = ~dec_fixed & ~dec_nopay & (regi_payloadlen > {1'b0, max_bytes});
    len_eff   = dec_clamp ? {1'b0, max_bytes} : regi_payloadlen;
    if (dec_nopay) begin
      dec_pylen = 13'd0;
    end else if (dec_fixed) begin
      dec_pylen = {5'd0, fixed_bits};
    end else begin
      dec_pylen = {len_eff, 3'b000} + {8'd0, hdr_bits};
    end
  end

  // Sequencer next-state, timeout counting and single-cycle pulses.
  always_comb begin
    state_d     = state_q;
    us_cnt_d    = us_cnt_q;
    pk_type_d   = pk_type_q;
    pylen_d     = pylen_q;
    crc_d       = crc_q;
    fec31_d     = fec31_q;
    fec32_d     = fec32_q;
    pk_encode_d = pk_encode_q;
    hdr_d       = hdr_q;
    brss_d      = brss_q;
    nopay_d     = nopay_q;
    err_d       = err_q;
    clamp_d     = clamp_q;
    py_st_p     = 1'b0;
    done_p      = 1'b0;

    if (abort) begin
      // Abort beats every other event; configuration is left untouched.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (tx_req || rx_req) begin
            pk_type_d   = eff_type;
            pylen_d     = dec_pylen;
            crc_d       = dec_crc;
            fec31_d     = dec_fec31;
            fec32_d     = dec_fec32;
            pk_encode_d = tx_req;
            hdr_d       = (hdr_bits != 5'd0);
            brss_d      = (hdr_bits == 5'd8);
            nopay_d     = dec_nopay;
            err_d       = 1'b0;
            clamp_d     = dec_clamp;
            state_d     = StWaitHdr;
          end
        end
        StWaitHdr: begin
          if (header_endp) state_d = nopay_q ? StDone : StStart;
        end
        StStart: begin
          py_st_p  = 1'b1;
          us_cnt_d = 12'd0;
          state_d  = StActive;
        end
        StActive: begin
          if (!py_period && !dec_py_period) begin
            state_d = StDone;
          end else if (p_1us) begin
            if (us_cnt_q == TimeoutUs - 12'd1) begin
              err_d   = 1'b1;
              state_d = StDone;
            end else begin
              us_cnt_d = us_cnt_q + 12'd1;
            end
          end
        end
        StDone: begin
          done_p  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and configuration registers.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q     <= StIdle;
      us_cnt_q    <= 12'd0;
      pk_type_q   <= 4'd0;
      pylen_q     <= 13'd0;
      crc_q       <= 1'b0;
      fec31_q     <= 1'b0;
      fec32_q     <= 1'b0;
      pk_encode_q <= 1'b0;
      hdr_q       <= 1'b0;
      brss_q      <= 1'b0;
      nopay_q     <= 1'b0;
      err_q       <= 1'b0;
      clamp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      us_cnt_q    <= us_cnt_d;
      pk_type_q   <= pk_type_d;
      pylen_q     <= pylen_d;
      crc_q       <= crc_d;
      fec31_q     <= fec31_d;
      fec32_q     <= fec32_d;
      pk_encode_q <= pk_encode_d;
      hdr_q       <= hdr_d;
      brss_q      <= brss_d;
      nopay_q     <= nopay_d;
      err_q       <= err_d;
      clamp_q     <= clamp_d;
    end
  end

  assign py_datvalid_p = p_1us & ((state_q == StStart) | (state_q == StActive));
  assign busy          = (state_q != StIdle);
  assign pk_type       = pk_type_q;
  assign pylenbit      = pylen_q;
  assign crcencode     = crc_q;
  assign fec31encode   = fec31_q;
  assign fec32encode   = fec32_q;
  assign pk_encode     = pk_encode_q;
  assign existpyheader = hdr_q;
  assign BRss          = brss_q;
  assign err_timeout   = err_q;
  assign len_clamped   = clamp_q;

endmodule

// File: tb/tb_py_sched.sv
// Self-checking bench for py_sched: directed scenarios plus randomized
// sequences against a table-driven reference model.
module tb_py_sched;

  logic        clk_6M = 1'b0;
  logic        rstz = 1'b0;
  logic        p_1us = 1'b0;
  logic        tx_req = 1'b0;
  logic        rx_req = 1'b0;
  logic        abort = 1'b0;
  logic        mpr = 1'b0;
  logic        ir = 1'b0;
  logic [3:0]  regi_packet_type = 4'd0;
  logic [9:0]  regi_payloadlen = 10'd0;
  logic        header_endp = 1'b0;
  logic        py_period = 1'b0;
  logic        dec_py_period = 1'b0;
  logic        py_st_p, py_datvalid_p;
  logic [3:0]  pk_type;
  logic [12:0] pylenbit;
  logic        crcencode, fec31encode, fec32encode, pk_encode;
  logic        existpyheader, BRss, busy, done_p, err_timeout, len_clamped;

  py_sched dut (
    .clk_6M          (clk_6M),
    .rstz            (rstz),
    .p_1us           (p_1us),
    .tx_req          (tx_req),
    .rx_req          (rx_req),
    .abort           (abort),
    .mpr             (mpr),
    .ir              (ir),
    .regi_packet_type(regi_packet_type),
    .regi_payloadlen (regi_payloadlen),
    .header_endp     (header_endp),
    .py_period       (py_period),
    .dec_py_period   (dec_py_period),
    .py_st_p         (py_st_p),
    .py_datvalid_p   (py_datvalid_p),
    .pk_type         (pk_type),
    .pylenbit        (pylenbit),
    .crcencode       (crcencode),
    .fec31encode     (fec31encode),
    .fec32encode     (fec32encode),
    .pk_encode       (pk_encode),
    .existpyheader   (existpyheader),
    .BRss            (BRss),
    .busy            (busy),
    .done_p          (done_p),
    .err_timeout     (err_timeout),
    .len_clamped     (len_clamped)
  );

  always #5 clk_6M = ~clk_6M;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference tables indexed by packet type.
  int max_bytes [16] = '{0, 0, 0, 17, 27, 0, 0, 0, 0, 29, 121, 183, 0, 0, 224, 339};
  int hdr_bits  [16] = '{0, 0, 0, 8, 8, 0, 0, 0, 0, 8, 16, 16, 0, 0, 16, 16};
  int fixed_len [16] = '{0, 0, 144, 0, 0, 80, 160, 240, 0, 0, 0, 0, 0, 0, 0, 0};
  logic [15:0] crc_mask   = 16'b1100_1100_0001_1100;
  logic [15:0] fec23_mask = 16'b0100_0100_0100_1100;
  logic [15:0] fec13_mask = 16'b0000_0000_0010_0000;

  typedef struct packed {
    logic [3:0]  ptype;
    logic [12:0] pylen;
    logic        crc, f31, f32, hdr, brss, clamped, nopay;
  } cfg_t;

  function automatic cfg_t model(input int t, input int len, input bit forced);
    cfg_t c;
    int   eff, b;
    eff     = forced ? 2 : t;
    c       = '0;
    c.ptype = 4'(eff);
    c.crc   = crc_mask[eff];
    c.f32   = fec23_mask[eff];
    c.f31   = fec13_mask[eff];
    if (fixed_len[eff] != 0) begin
      c.pylen = 13'(fixed_len[eff]);
    end else if (max_bytes[eff] != 0) begin
      b         = (len > max_bytes[eff]) ? max_bytes[eff] : len;
      c.clamped = (len > max_bytes[eff]);
      c.pylen   = 13'(b * 8 + hdr_bits[eff]);
    end else begin
      c.nopay = 1'b1;
    end
    c.hdr  = (hdr_bits[eff] > 0);
    c.brss = (hdr_bits[eff] == 8);
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_6M);
    #1;
  endtask

  // mode: 0 = normal end, 1 = abort in ACTIVE, 2 = timeout
  task automatic run_seq(input int t, input int len, input bit m, input bit irr,
                         input bit tx, input bit rx, input int act_cycles, input int mode);
    cfg_t e;
    e = model(t, len, m | irr);
    regi_packet_type = 4'(t);
    regi_payloadlen  = 10'(len);
    mpr    = m;
    ir     = irr;
    tx_req = tx;
    rx_req = rx;
    tick();
    tx_req = 1'b0;
    rx_req = 1'b0;
    // Disturb request-time inputs to confirm the configuration was latched.
    regi_packet_type = 4'($urandom);
    regi_payloadlen  = 10'($urandom);
    mpr = 1'b0;
    ir  = 1'b0;
    #1;
    check("req_busy", 32'(busy), 32'd1);
    check("pk_type", 32'(pk_type), 32'(e.ptype));
    check("pylenbit", 32'(pylenbit), 32'(e.pylen));
    check("crcencode", 32'(crcencode), 32'(e.crc));
    check("fec31encode", 32'(fec31encode), 32'(e.f31));
    check("fec32encode", 32'(fec32encode), 32'(e.f32));
    check("pk_encode", 32'(pk_encode), 32'(tx));
    check("existpyheader", 32'(existpyheader), 32'(e.hdr));
    check("BRss", 32'(BRss), 32'(e.brss));
    check("len_clamped", 32'(len_clamped), 32'(e.clamped));
    check("err_cleared", 32'(err_timeout), 32'd0);

    // Waiting for header: strobe gated off, further requests ignored.
    repeat ($urandom_range(0, 3)) begin
      p_1us  = 1'($urandom);
      tx_req = 1'($urandom);
      #1;
      check("wait_datvalid", 32'(py_datvalid_p), 32'd0);
      check("wait_st", 32'(py_st_p), 32'd0);
      tick();
    end
    p_1us  = 1'b0;
    tx_req = 1'b0;
    header_endp = 1'b1;
    #1;
    check("hdr_cycle_st", 32'(py_st_p), 32'd0);
    tick();
    header_endp = 1'b0;

    if (e.nopay) begin
      p_1us = 1'b1;
      #1;
      check("nopay_done", 32'(done_p), 32'd1);
      check("nopay_st", 32'(py_st_p), 32'd0);
      check("nopay_datvalid", 32'(py_datvalid_p), 32'd0);
      tick();
      p_1us = 1'b0;
      #1;
      check("nopay_idle", 32'(busy), 32'd0);
      return;
    end

    p_1us     = 1'($urandom);
    py_period = 1'b1;
    #1;
    check("start_st", 32'(py_st_p), 32'd1);
    check("start_done", 32'(done_p), 32'd0);
    check("start_datvalid", 32'(py_datvalid_p), 32'(p_1us));
    tick();

    if (mode == 2) begin
      for (int i = 1; i <= 3000; i++) begin
        p_1us = 1'b1;
        #1;
        if (i == 3000) check("to_not_early", 32'(done_p), 32'd0);
        tick();
      end
      p_1us = 1'b0;
      #1;
      check("to_done", 32'(done_p), 32'd1);
      check("to_err", 32'(err_timeout), 32'd1);
      tick();
      py_period = 1'b0;
      #1;
      check("to_idle", 32'(busy), 32'd0);
      check("to_err_sticky", 32'(err_timeout), 32'd1);
      return;
    end

    for (int i = 0; i < act_cycles; i++) begin
      py_period     = 1'($urandom);
      dec_py_period = py_period ? 1'($urandom) : 1'b1;
      p_1us         = 1'($urandom);
      header_endp   = 1'($urandom);
      #1;
      check("act_datvalid", 32'(py_datvalid_p), 32'(p_1us));
      check("act_st", 32'(py_st_p), 32'd0);
      check("act_done", 32'(done_p), 32'd0);
      tick();
    end
    header_endp   = 1'b0;
    p_1us         = 1'b0;
    py_period     = 1'b0;
    dec_py_period = 1'b0;

    if (mode == 1) begin
      abort = 1'b1;
      #1;
      check("abort_done", 32'(done_p), 32'd0);
      tick();
      abort = 1'b0;
      #1;
      check("abort_idle", 32'(busy), 32'd0);
      check("abort_nodone", 32'(done_p), 32'd0);
      check("abort_hold_len", 32'(pylenbit), 32'(e.pylen));
      return;
    end

    #1;
    check("exit_cycle_done", 32'(done_p), 32'd0);
    tick();
    check("end_done", 32'(done_p), 32'd1);
    check("end_busy", 32'(busy), 32'd1);
    check("end_err", 32'(err_timeout), 32'd0);
    tick();
    check("end_idle", 32'(busy), 32'd0);
    check("end_nodone", 32'(done_p), 32'd0);
  endtask

  function automatic logic [28:0] all_outs();
    return {py_st_p, py_datvalid_p, pk_type, pylenbit, crcencode, fec31encode, fec32encode,
            pk_encode, existpyheader, BRss, busy, done_p, err_timeout, len_clamped};
  endfunction

  initial begin
    #10ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_6M);
    #1;
    check("reset_outs", 32'(all_outs()), 32'd0);
    rstz = 1'b1;
    tick();

    // header_endp while idle is ignored.
    header_endp = 1'b1;
    #1;
    check("idle_hdr_st", 32'(py_st_p), 32'd0);
    tick();
    header_endp = 1'b0;
    check("idle_hdr_busy", 32'(busy), 32'd0);

    run_seq(3, 10, 0, 0, 1, 0, 4, 0);
    check("dm1_pylen", 32'(pylenbit), 32'd88);
    run_seq(4, 20, 1, 0, 0, 1, 3, 0);
    check("mpr_type", 32'(pk_type), 32'd2);
    check("mpr_pylen", 32'(pylenbit), 32'd144);
    run_seq(15, 400, 0, 0, 1, 0, 2, 0);
    check("dh5_pylen", 32'(pylenbit), 32'd2728);
    check("dh5_clamp", 32'(len_clamped), 32'd1);
    run_seq(0, 5, 0, 0, 1, 0, 0, 0);
    run_seq(3, 10, 0, 1, 1, 0, 0, 2);
    run_seq(10, 50, 0, 0, 1, 1, 3, 1);
    check("both_req_tx", 32'(pk_encode), 32'd1);

    // Reset asserted mid-ACTIVE.
    regi_packet_type = 4'hF;
    regi_payloadlen  = 10'd100;
    tx_req = 1'b1;
    tick();
    tx_req = 1'b0;
    header_endp = 1'b1;
    tick();
    header_endp = 1'b0;
    py_period = 1'b1;
    tick();
    tick();
    check("pre_reset_busy", 32'(busy), 32'd1);
    rstz = 1'b0;
    #1;
    check("midrun_reset", 32'(all_outs()), 32'd0);
    py_period = 1'b0;
    tick();
    rstz = 1'b1;
    tick();

    for (int n = 0; n < 60; n++) begin
      int  t, len, r, mode;
      bit  m, irr;
      t    = $urandom_range(0, 15);
      len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 60);
      m    = ($urandom_range(0, 7) == 0);
      irr  = ($urandom_range(0, 7) == 0);
      r    = $urandom_range(0, 2);
      mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
      run_seq(t, len, m, irr, r != 1, r != 0, $urandom_range(0, 12), mode);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
